// File: rtl/fpu_muldiv_issue_ctrl_pkg.sv
// Shared types and default latencies for the FPU mul/div issue controller.
package fpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FPU_MUL = 3'b010,
    FPU_DIV = 3'b011
  } fpu_op_e;

  typedef enum logic {
    ISSUE    = 1'b0,
    DIV_WAIT = 1'b1
  } fsm_e;

  localparam int unsigned FPU_MUL_LAT = 4;
  localparam int unsigned FPU_DIV_LAT = 9;

endpackage

// File: rtl/fpu_muldiv_issue_ctrl_if.sv
// Core-side request/response bundle of the FPU mul/div issue controller.
interface fpu_muldiv_issue_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_opa;
  logic [32*NUM_REQ-1:0] req_opb;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic [3:0]            rsp_exc;

  modport master (
    output req_valid, req_op, req_opa, req_opb,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_exc
  );

  modport slave (
    input  req_valid, req_op, req_opa, req_opb,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_exc
  );

endinterface

// File: rtl/fpu_muldiv_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned ID_W = $clog2(N);

  logic [ID_W-1:0] ptr_q;
  logic            found;
  int unsigned     idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (ptr_q + i) % N;
      if (!found && req[ID_W'(idx)]) begin
        found              = 1'b1;
        gnt[ID_W'(idx)]    = 1'b1;
        gnt_id             = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_id == ID_W'(N-1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/fpu_muldiv_issue_ctrl.sv
// Issues mul/div ops from NUM_REQ requesters onto one fixed-latency FPU datapath
// and routes each result back by requester ID. FPU_ISSUE_PERF_EN adds perf counters.
module fpu_muldiv_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MUL_LAT = FPU_MUL_LAT,
  parameter int unsigned DIV_LAT = FPU_DIV_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fpu_muldiv_issue_ctrl_if.slave   core,
  output logic                     fpu_start,
  output logic [2:0]               fpu_op,
  output logic [31:0]              opa,
  output logic [31:0]              opb,
  input  logic [31:0]              fpu_out,
  input  logic [3:0]               fpu_exc,
  output logic                     busy
`ifdef FPU_ISSUE_PERF_EN
  ,
  output logic [31:0]              perf_mul_cnt,
  output logic [31:0]              perf_div_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DIV_LAT);

  if (DIV_LAT <= MUL_LAT || MUL_LAT < 1) begin : g_bad_lat
    $error("fpu_muldiv_issue_ctrl: DIV_LAT must exceed MUL_LAT and MUL_LAT must be >= 1");
  end

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } trk_t;

  fsm_e              state_q;
  logic [CNT_W-1:0]  div_cnt_q;
  logic              fpu_start_q;
  logic [2:0]        fpu_op_q;
  logic [31:0]       opa_q, opb_q;
  logic [ID_W-1:0]   issue_id_q;
  trk_t              trk_q [DIV_LAT];
  trk_t              trk_d [DIV_LAT];
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [31:0]       rsp_data_q;
  logic [3:0]        rsp_exc_q;

  logic              issue_en;
  logic [NUM_REQ-1:0] arb_req, gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              xfer;
  logic [2:0]        sel_op;
  logic [31:0]       sel_opa, sel_opb;
  logic              sel_div;
  logic              trk_any;

  // Grants open in ISSUE and on the last DIV_WAIT cycle; held off while in reset.
  assign issue_en = rst_n && ((state_q == ISSUE) || (div_cnt_q == '0));
  assign arb_req  = core.req_valid & {NUM_REQ{issue_en}};
  assign xfer     = |gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  assign core.req_ready = gnt;

  always_comb begin
    sel_op  = '0;
    sel_opa = '0;
    sel_opb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op  = core.req_op[3*i +: 3];
        sel_opa = core.req_opa[32*i +: 32];
        sel_opb = core.req_opb[32*i +: 32];
      end
    end
  end

  // Anything other than a div opcode is issued as a mul.
  assign sel_div = (sel_op == FPU_DIV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ISSUE;
      div_cnt_q   <= '0;
      fpu_start_q <= 1'b0;
      fpu_op_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      issue_id_q  <= '0;
    end else begin
      fpu_start_q <= xfer;
      if (xfer) begin
        fpu_op_q   <= sel_div ? FPU_DIV : FPU_MUL;
        opa_q      <= sel_opa;
        opb_q      <= sel_opb;
        issue_id_q <= gnt_id;
      end
      case (state_q)
        ISSUE: begin
          if (xfer && sel_div) begin
            state_q   <= DIV_WAIT;
            div_cnt_q <= CNT_W'(DIV_LAT-1);
          end
        end
        DIV_WAIT: begin
          if (div_cnt_q != '0) begin
            div_cnt_q <= div_cnt_q - CNT_W'(1);
          end else if (xfer && sel_div) begin
            div_cnt_q <= CNT_W'(DIV_LAT-1);
          end else begin
            state_q <= ISSUE;
          end
        end
      endcase
    end
  end

  // Ops enter the tracker at a tap matching their latency so they reach tap 0
  // exactly when the datapath presents their result.
  always_comb begin
    for (int unsigned i = 0; i < DIV_LAT-1; i++) begin
      trk_d[i] = trk_q[i+1];
    end
    trk_d[DIV_LAT-1] = '0;
    if (fpu_start_q) begin
      if (fpu_op_q == FPU_DIV) trk_d[DIV_LAT-1] = '{v: 1'b1, id: issue_id_q};
      else                     trk_d[MUL_LAT-1] = '{v: 1'b1, id: issue_id_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIV_LAT; i++) trk_q[i] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DIV_LAT; i++) trk_q[i] <= trk_d[i];
      rsp_valid_q <= trk_q[0].v;
      if (trk_q[0].v) begin
        rsp_id_q   <= trk_q[0].id;
        rsp_data_q <= fpu_out;
        rsp_exc_q  <= fpu_exc;
      end
    end
  end

  always_comb begin
    trk_any = 1'b0;
    for (int unsigned i = 0; i < DIV_LAT; i++) trk_any = trk_any | trk_q[i].v;
  end

  assign fpu_start      = fpu_start_q;
  assign fpu_op         = fpu_op_q;
  assign opa            = opa_q;
  assign opb            = opb_q;
  assign busy           = trk_any | (state_q == DIV_WAIT) | fpu_start_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_id    = rsp_id_q;
  assign core.rsp_data  = rsp_data_q;
  assign core.rsp_exc   = rsp_exc_q;

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_mul_q, perf_div_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_mul_q   <= '0;
      perf_div_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (fpu_start_q && fpu_op_q != FPU_DIV) perf_mul_q <= perf_mul_q + 32'd1;
      if (fpu_start_q && fpu_op_q == FPU_DIV) perf_div_q <= perf_div_q + 32'd1;
      if (|core.req_valid && !(|core.req_ready)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_mul_cnt   = perf_mul_q;
  assign perf_div_cnt   = perf_div_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

  a_legal_op: assert property (@(posedge clk) disable iff (!rst_n)
    xfer |-> (sel_op == FPU_MUL || sel_op == FPU_DIV));

endmodule

// File: tb/tb_fpu_muldiv_issue_ctrl.sv
// Scoreboard bench for fpu_muldiv_issue_ctrl with a fixed-latency datapath model.
module tb_fpu_muldiv_issue_ctrl;
  import fpu_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int ML = 4;
  localparam int DL = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fpu_start;
  logic [2:0]  fpu_op;
  logic [31:0] opa, opb;
  logic [31:0] fpu_out = '0;
  logic [3:0]  fpu_exc = '0;
  logic        busy;
`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] perf_mul_cnt, perf_div_cnt, perf_stall_cnt;
`endif

  fpu_muldiv_issue_ctrl_if #(.NUM_REQ(NR)) core_if ();

  fpu_muldiv_issue_ctrl #(.NUM_REQ(NR), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core      (core_if.slave),
    .fpu_start (fpu_start),
    .fpu_op    (fpu_op),
    .opa       (opa),
    .opb       (opb),
    .fpu_out   (fpu_out),
    .fpu_exc   (fpu_exc),
    .busy      (busy)
`ifdef FPU_ISSUE_PERF_EN
    ,
    .perf_mul_cnt   (perf_mul_cnt),
    .perf_div_cnt   (perf_div_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          start_cyc;
    int          rsp_cyc;
  } txn_t;

  req_t        pend [NR][$];
  txn_t        iss_q [$];
  txn_t        rsp_q [$];
  logic [35:0] model [int];
  int cyc = 0, n_tests = 0, n_fail = 0, ptr = 0, block_until = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in datapath: distinct, operand-dependent result and flags per op.
  function automatic logic [35:0] dp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = (op == 3'b011) ? (a - b) : (a ^ {b[15:0], b[31:16]});
    return {a[3:0] ^ b[31:28] ^ {3'b000, op[0]}, r};
  endfunction

  // Monitor: one pass per cycle, 1 time unit after the rising edge.
  always begin : mon
    txn_t e;
    logic be;
    int   lat;
    @(posedge clk);
    #1;
    cyc++;
    if (fpu_start) begin
      if (iss_q.size() == 0) chk("start_spurious", 1, 0);
      else begin
        e = iss_q.pop_front();
        chk("start_cyc", cyc, e.start_cyc);
        chk("fpu_op", fpu_op, e.op);
        chk("opa", opa, e.a);
        chk("opb", opb, e.b);
      end
      lat = (fpu_op == 3'b011) ? DL : ML;
      model[cyc + lat] = dp(fpu_op, opa, opb);
    end
    if (model.exists(cyc)) begin
      {fpu_exc, fpu_out} = model[cyc];
      model.delete(cyc);
    end else begin
      fpu_out = 32'hBAD0_0000 ^ 32'(cyc);
      fpu_exc = 4'hF;
    end
    if (core_if.rsp_valid) begin
      if (rsp_q.size() == 0) chk("rsp_spurious", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_cyc", cyc, e.rsp_cyc);
        chk("rsp_id", core_if.rsp_id, e.id);
        chk("rsp_data_exc", {core_if.rsp_exc, core_if.rsp_data}, dp(e.op, e.a, e.b));
      end
    end
    be = 1'b0;
    foreach (rsp_q[k]) if (rsp_q[k].start_cyc <= cyc && rsp_q[k].rsp_cyc > cyc) be = 1'b1;
    chk("busy", busy, be);
  end

  task automatic push(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_t q;
    q.op = op; q.a = a; q.b = b;
    pend[r].push_back(q);
  endtask

  // One cycle of stimulus: present head of each requester queue, check grant against RR model.
  task automatic step();
    logic [NR-1:0] v, rexp;
    int g;
    txn_t t;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      v[i] = (pend[i].size() > 0);
      if (v[i]) begin
        core_if.req_op[3*i +: 3]   = pend[i][0].op;
        core_if.req_opa[32*i +: 32] = pend[i][0].a;
        core_if.req_opb[32*i +: 32] = pend[i][0].b;
      end
    end
    core_if.req_valid = v;
    #1;
    rexp = '0;
    g = -1;
    if (cyc >= block_until) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (ptr + k) % NR;
        if (g < 0 && v[j]) g = j;
      end
    end
    if (g >= 0) rexp[g] = 1'b1;
    if (|v) chk("req_ready", core_if.req_ready, rexp);
    if (g >= 0 && core_if.req_ready[g]) begin
      t.id = g; t.op = pend[g][0].op; t.a = pend[g][0].a; t.b = pend[g][0].b;
      t.start_cyc = cyc + 1;
      t.rsp_cyc = cyc + 2 + ((t.op == 3'b011) ? DL : ML);
      iss_q.push_back(t);
      rsp_q.push_back(t);
      void'(pend[g].pop_front());
      ptr = (g + 1) % NR;
      if (t.op == 3'b011) block_until = cyc + DL;
    end
  endtask

  function automatic bit work_left();
    bit w;
    w = (rsp_q.size() > 0) || (iss_q.size() > 0);
    for (int i = 0; i < NR; i++) if (pend[i].size() > 0) w = 1'b1;
    return w;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    step();
    while (work_left() && n < 500) begin
      step();
      n++;
    end
    if (work_left()) chk("drain_timeout", 1, 0);
    repeat (2) step();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) pend[i].delete();
    iss_q.delete();
    rsp_q.delete();
    model.delete();
    ptr = 0;
    block_until = 0;
    core_if.req_valid = '1;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_req_ready", core_if.req_ready, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_opa_opb", {opa, opb}, 0);
    chk("rst_rsp_valid", core_if.rsp_valid, 0);
    chk("rst_rsp_fields", {core_if.rsp_id, core_if.rsp_exc, core_if.rsp_data}, 0);
    chk("rst_busy", busy, 0);
    core_if.req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    core_if.req_valid = '0;
    core_if.req_op    = '0;
    core_if.req_opa   = '0;
    core_if.req_opb   = '0;
    do_reset(3);

    push(0, FPU_MUL, 32'h4000_0000, 32'h4040_0000);
    drain();

    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 3; k++) push(r, FPU_MUL, $urandom, $urandom);
    drain();

    push(1, FPU_DIV, 32'h4120_0000, 32'h4000_0000);
    push(2, FPU_MUL, 32'h3F80_0000, 32'hC000_0000);
    drain();

    push(0, FPU_MUL, 32'h1111_2222, 32'h3333_4444);
    push(1, FPU_MUL, 32'h5555_6666, 32'h7777_8888);
    push(2, FPU_DIV, 32'h9999_AAAA, 32'hBBBB_CCCC);
    drain();

    for (int k = 0; k < 24; k++)
      push($urandom_range(0, NR-1), ($urandom_range(0, 3) == 0) ? FPU_DIV : FPU_MUL, $urandom, $urandom);
    drain();

    push(3, FPU_DIV, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    while (block_until == 0 && cyc < 100000) step();
    repeat (3) step();
    do_reset(1);
    push(2, FPU_MUL, 32'h0102_0304, 32'h0506_0708);
    push(0, FPU_MUL, 32'h0A0B_0C0D, 32'h0E0F_1011);
    drain();
    repeat (DL + 4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
